// File: rtl/myown_pipe.sv
// WIDTH-bit XOR/flop/inverter cell behind a DEPTH-stage valid/ready pipeline with a cross-beat history register.
// Optional: define MYOWN_PIPE_PARITY_EN to add out_par, the XOR-reduction of out1 carried with each beat.
module myown_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3
`ifdef MYOWN_PIPE_PARITY_EN
  ,
  output logic             out_par
`endif
);

  // Handshake: a beat transfers on an edge where valid && ready are both high.
  // Advance is global, so in_ready only depends on the last stage and out_ready,
  // never on in_valid; a stalled full pipe therefore back-pressures the input.
  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] r3;
  logic [WIDTH-1:0] prev_x;

  logic [DEPTH-1:0] stg_valid;
  logic [WIDTH-1:0] stg_r1 [DEPTH];
  logic [WIDTH-1:0] stg_r2 [DEPTH];
  logic [WIDTH-1:0] stg_r3 [DEPTH];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  assign x  = in1 ^ in2;
  assign r3 = ~x;
  assign r2 = in3;
  assign r1 = prev_x ^ ~in3;

  // History only moves on a real acceptance, so bubbles and stalls leave it intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_x <= '0;
    end else if (accept) begin
      prev_x <= x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
    end else if (adv) begin
      stg_valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stg_valid[i] <= stg_valid[i-1];
      end
    end
  end

  // Bubble slots keep their old data; only a valid beat overwrites a stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg_r1[i] <= '0;
        stg_r2[i] <= '0;
        stg_r3[i] <= '0;
      end
    end else if (adv) begin
      if (in_valid) begin
        stg_r1[0] <= r1;
        stg_r2[0] <= r2;
        stg_r3[0] <= r3;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (stg_valid[i-1]) begin
          stg_r1[i] <= stg_r1[i-1];
          stg_r2[i] <= stg_r2[i-1];
          stg_r3[i] <= stg_r3[i-1];
        end
      end
    end
  end

  assign out_valid = stg_valid[DEPTH-1];
  assign out1      = stg_r1[DEPTH-1];
  assign out2      = stg_r2[DEPTH-1];
  assign out3      = stg_r3[DEPTH-1];

`ifdef MYOWN_PIPE_PARITY_EN
  logic [DEPTH-1:0] stg_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_par <= '0;
    end else if (adv) begin
      if (in_valid) begin
        stg_par[0] <= ^r1;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (stg_valid[i-1]) begin
          stg_par[i] <= stg_par[i-1];
        end
      end
    end
  end

  assign out_par = stg_par[DEPTH-1];
`endif

endmodule

// File: tb/tb_myown_pipe.sv
// Directed bench for myown_pipe (WIDTH=4, DEPTH=2) with an expected-queue scoreboard on the output port.
module tb_myown_pipe;

  localparam int W = 4;
  localparam int D = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] in3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic [W-1:0] out3;
`ifdef MYOWN_PIPE_PARITY_EN
  logic         out_par;
`endif

  int errors = 0;
  int checks = 0;

  logic [3*W-1:0] exp_q[$];
  logic [W-1:0]   mdl_prev;

  myown_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3)
`ifdef MYOWN_PIPE_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: observes transfers at negedge, where inputs and outputs are settled
  always @(negedge clk) begin
    logic [3*W-1:0] e;
    if (rst) begin
      exp_q.delete();
      mdl_prev = '0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_beat: got out=%h/%h/%h with no beat outstanding", out1, out2, out3);
        end else begin
          e = exp_q.pop_front();
          if ({out1, out2, out3} !== e) begin
            errors++;
            $display("FAIL sb_beat: got %h/%h/%h expected %h/%h/%h",
                     out1, out2, out3, e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
          end
`ifdef MYOWN_PIPE_PARITY_EN
          if (out_par !== ^e[3*W-1:2*W]) begin
            errors++;
            $display("FAIL sb_par: got %b expected %b", out_par, ^e[3*W-1:2*W]);
          end
`endif
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({mdl_prev ^ ~in3, in3, ~(in1 ^ in2)});
        mdl_prev = in1 ^ in2;
      end
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    in1 = a;
    in2 = b;
    in3 = c;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) cycle();
    checks++;
    if (out_valid !== 1'b0 || {out1, out2, out3} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: got v=%b out=%h/%h/%h rdy=%b expected v=0 out=0/0/0 rdy=1",
               out_valid, out1, out2, out3, in_ready);
    end
    rst = 1'b0;
    repeat (2) cycle();
    checks++;
    if (out_valid !== 1'b0 || {out1, out2, out3} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got v=%b out=%h/%h/%h rdy=%b expected v=0 out=0/0/0 rdy=1",
               out_valid, out1, out2, out3, in_ready);
    end
  endtask

  task automatic test_single_beats();
    out_ready = 1'b1;
    drive(4'h3, 4'h5, 4'hF);
    cycle();
    drive(4'hA, 4'h0, 4'h0);
    cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || {out1, out2, out3} !== 12'h0F9) begin
      errors++;
      $display("FAIL beat0: got v=%b out=%h/%h/%h expected v=1 out=0/f/9", out_valid, out1, out2, out3);
    end
`ifdef MYOWN_PIPE_PARITY_EN
    checks++;
    if (out_par !== 1'b0) begin
      errors++;
      $display("FAIL beat0_par: got %b expected 0", out_par);
    end
`endif
    cycle();
    checks++;
    if (out_valid !== 1'b1 || {out1, out2, out3} !== 12'h905) begin
      errors++;
      $display("FAIL beat1_prev_x: got v=%b out=%h/%h/%h expected v=1 out=9/0/5", out_valid, out1, out2, out3);
    end
`ifdef MYOWN_PIPE_PARITY_EN
    checks++;
    if (out_par !== 1'b0) begin
      errors++;
      $display("FAIL beat1_par: got %b expected 0", out_par);
    end
`endif
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  // prev_x enters at 0xA; expected tuples worked by hand from that history
  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(4'h1, 4'h2, 4'h4);
    cycle();
    drive(4'hF, 4'h0, 4'h8);
    cycle();
    out_ready = 1'b0;
    drive(4'h5, 4'h5, 4'h3);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out1, out2, out3} !== 12'h14C) begin
        errors++;
        $display("FAIL stall_stable[%0d]: got v=%b rdy=%b out=%h/%h/%h expected v=1 rdy=0 out=1/4/c",
                 i, out_valid, in_ready, out1, out2, out3);
      end
    end
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || {out1, out2, out3} !== 12'h480) begin
      errors++;
      $display("FAIL release_b1: got v=%b out=%h/%h/%h expected v=1 out=4/8/0", out_valid, out1, out2, out3);
    end
    drive(4'h6, 4'h9, 4'h0);
    cycle();
    checks++;
    if (out_valid !== 1'b1 || {out1, out2, out3} !== 12'h33F) begin
      errors++;
      $display("FAIL release_b2: got v=%b out=%h/%h/%h expected v=1 out=3/3/f", out_valid, out1, out2, out3);
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || {out1, out2, out3} !== 12'hF00) begin
      errors++;
      $display("FAIL release_b3: got v=%b out=%h/%h/%h expected v=1 out=f/0/0", out_valid, out1, out2, out3);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    drive(4'h2, 4'h1, 4'h5);
    cycle();
    drive(4'h4, 4'h4, 4'h6);
    cycle();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {out1, out2, out3} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b out=%h/%h/%h expected v=0 out=0/0/0", out_valid, out1, out2, out3);
    end
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
    drive(4'h1, 4'h0, 4'h0);
    cycle();
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || {out1, out2, out3} !== 12'hF0E) begin
      errors++;
      $display("FAIL prev_x_cleared: got v=%b out=%h/%h/%h expected v=1 out=f/0/e", out_valid, out1, out2, out3);
    end
    cycle();
  endtask

  task automatic test_random();
    int budget;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in1 = W'($urandom_range(0, 15));
      in2 = W'($urandom_range(0, 15));
      in3 = W'($urandom_range(0, 15));
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      cycle();
      budget++;
    end
    cycle();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got %0d beats outstanding v=%b expected 0 outstanding v=0",
               exp_q.size(), out_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1 = '0;
    in2 = '0;
    in3 = '0;
    test_reset();
    test_single_beats();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
